// File: rtl/divisor_pkg.sv
// Shared definitions for the divisor_4bit restoring divider:
// default width, FSM state encodings and step-counter width.
package divisor_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StDone = 2'b10
   } state_t;

   // Counter must reach N-1 and still leave headroom for the increment.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

   localparam int unsigned DEF_CNT_WIDTH = $clog2(DEF_WIDTH) + 1;

endpackage

// File: rtl/divisor_4bit_if.sv
// Request/result bundle for divisor_4bit.
// Optional macro DIVISOR_4BIT_DIV0_EN adds the div_zero result flag.
interface divisor_4bit_if
   import divisor_pkg::*;
#(
   parameter int unsigned N = DEF_WIDTH
);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] q;
   logic [N-1:0] r;
`ifdef DIVISOR_4BIT_DIV0_EN
   logic         div_zero;
`endif

   modport master (
      output start, a, b,
      input  busy, done, q, r
`ifdef DIVISOR_4BIT_DIV0_EN
      , input div_zero
`endif
   );

   modport slave (
      input  start, a, b,
      output busy, done, q, r
`ifdef DIVISOR_4BIT_DIV0_EN
      , output div_zero
`endif
   );

endinterface

// File: rtl/resta_paso.sv
// One restoring-division step: trial subtract, keep the difference when
// there is no borrow, otherwise restore the partial remainder.
module resta_paso
   import divisor_pkg::*;
#(
   parameter int unsigned W = DEF_WIDTH + 1
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] next_rem,
   output logic         q_bit
);

   // Extra top bit carries the borrow out of the subtraction.
   logic [W:0] diff;

   // Trial subtraction and restore select.
   always_comb begin
      diff     = {1'b0, rem} - {1'b0, divisor};
      q_bit    = ~diff[W];
      next_rem = q_bit ? diff[W-1:0] : rem;
   end

endmodule

// File: rtl/divisor_4bit.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIVISOR_4BIT_DIV0_EN registers a divide-by-zero flag.
module divisor_4bit
   import divisor_pkg::*;
#(
   parameter int unsigned N = DEF_WIDTH
) (
   input logic          clk,
   input logic          rst,
   divisor_4bit_if.slave bus
);

   localparam int unsigned CW = cnt_width(N);

   state_t        state_q, state_d;
   logic [N-1:0]  dvd_q;   // dividend, shifted left each step
   logic [N-1:0]  dvs_q;
   logic [N-1:0]  rem_q;   // restored remainder always fits in N bits
   logic [N-1:0]  quo_q;
   logic [N-1:0]  q_q;
   logic [N-1:0]  r_q;
   logic [CW-1:0] cnt_q;
   logic [N:0]    rem_in;
   logic [N:0]    next_rem;
   logic          q_bit;
   logic          unused_rem_msb;
   logic          accept;
   logic          last_step;

   assign rem_in         = {rem_q, dvd_q[N-1]};
   assign unused_rem_msb = next_rem[N];

   resta_paso #(
      .W (N + 1)
   ) u_paso (
      .rem      (rem_in),
      .divisor  ({1'b0, dvs_q}),
      .next_rem (next_rem),
      .q_bit    (q_bit)
   );

   // Next-state and status outputs.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      last_step = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            bus.busy = 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               last_step = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            bus.done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture and per-step datapath update.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         dvd_q <= bus.a;
         dvs_q <= bus.b;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else if (state_q == StCalc) begin
         dvd_q <= dvd_q << 1;
         rem_q <= next_rem[N-1:0];
         quo_q <= {quo_q[N-2:0], q_bit};
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Results load only on the final step and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
         r_q <= '0;
      end else if (last_step) begin
         q_q <= {quo_q[N-2:0], q_bit};
         r_q <= next_rem[N-1:0];
      end
   end

   assign bus.q = q_q;
   assign bus.r = r_q;

`ifdef DIVISOR_4BIT_DIV0_EN
   logic dz_q;

   // Divide-by-zero flag, registered alongside Q/R.
   always_ff @(posedge clk) begin
      if (rst) begin
         dz_q <= 1'b0;
      end else if (last_step) begin
         dz_q <= (dvs_q == '0);
      end
   end

   assign bus.div_zero = dz_q;
`endif

endmodule

// File: doc/divisor_4bit.md
DIVISOR_4BIT -- requirements
Module: divisor_4bit

Interface
REQ-001 The block SHALL have parameter N, default 4: operand, quotient and remainder width in bits; only N=4 is required to be verified.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 Clk  input  1  clock; all state changes on the rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request a division; sampled only in IDLE.
REQ-006 A  input  N  dividend, unsigned, captured on the accepted Start.
REQ-007 B  input  N  divisor, unsigned, captured on the accepted Start.
REQ-008 Busy  output  1  high while iterating (CALC).
REQ-009 Done  output  1  one-cycle pulse: Q and R are valid.
REQ-010 Q  output  N  quotient, held until the next completion.
REQ-011 R  output  N  remainder, held until the next completion.
REQ-012 DivZero  output  1  divisor was zero; port exists only with DIVISOR_4BIT_DIV0_EN (see REQ-025).

Function
REQ-013 The block SHALL use the restoring algorithm: one quotient bit per cycle, MSB first, with an (N+1)-bit partial remainder and a trial subtraction each step.
REQ-014 The FSM SHALL have the states IDLE, CALC and DONE; reset enters IDLE.
- IDLE: Start=1 -> CALC. This edge captures A and B, clears the partial remainder and sets the step counter to 0.
- CALC: the counter runs over N edges; the Nth step edge -> DONE and loads Q/R.
- DONE: lasts 1 cycle, then -> IDLE unconditionally.
REQ-015 Latency SHALL be N+1 rising edges from the accepting edge; for N=4, Done is high in the cycle after edge 4, counting the accept edge as edge 0.
REQ-016 Each CALC step SHALL compute rem = {rem[N-1:0], next dividend bit} and trial = rem - {1'b0, B}; with no borrow, rem = trial and q bit = 1; otherwise rem is restored and q bit = 0.
REQ-017 Busy SHALL be 1 exactly in CALC; Done SHALL be 1 exactly in DONE; Busy and Done SHALL never be high together.
REQ-018 Start in CALC or DONE SHALL be ignored: no queuing, and operands do not change.
REQ-019 A and B changing after acceptance SHALL NOT affect the result.
REQ-020 Q and R SHALL change only on the edge entering DONE; otherwise they hold.
REQ-021 B=0 SHALL complete with the normal latency and give Q = all ones and R = A, which follows naturally from REQ-016.
REQ-022 Invariant on every completion with B!=0: A == Q*B + R and R < B.

Reset
REQ-023 Rst=1 at a clock edge SHALL force the following, overriding any operation in flight (the aborted operation never produces Done):
- state IDLE; Busy=0; Done=0; Q=0; R=0; DivZero=0 (when present).
REQ-024 Start held high during the reset edge SHALL NOT be accepted; the earliest acceptance is the first edge with Rst=0.

Configuration
REQ-025 With DIVISOR_4BIT_DIV0_EN defined, the DivZero port SHALL exist and be registered with Q/R on entry to DONE: 1 if the captured B==0, else 0. It holds until the next completion or reset.
REQ-026 Without DIVISOR_4BIT_DIV0_EN, the DivZero port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Shared package divisor_pkg SHALL hold:
- the default width constant;
- the state encodings IDLE=2'b00, CALC=2'b01, DONE=2'b10;
- the step-counter width, $clog2(N)+1.
REQ-028 The trial subtract/restore step SHALL be a sub-module resta_paso, (N+1)-bit, combinational: inputs rem and divisor; outputs next_rem and q_bit. The top holds the FSM, counter and registers.

Verification
REQ-029 A=13, B=3, Start pulse -> Busy for 4 cycles, then Done=1 for one cycle with Q=4, R=1, then Done=0.
REQ-030 A=7, B=9 -> Q=0, R=7; A=15, B=1 -> Q=15, R=0; back-to-back requests, each Start issued the cycle after Done -> both correct, same latency.
REQ-031 A=9, B=0 -> Q=15, R=9 at normal latency; with the macro, DivZero=1. A following A=8, B=2 -> Q=4, R=0, DivZero=0.
REQ-032 Start pulsed again at step 2 of 13/3 with A=2, B=1 -> ignored; result still Q=4, R=1, with a single Done.
REQ-033 Rst=1 at step 2 of 13/3 -> next cycle IDLE, Busy=0, Q=0, R=0, no Done; a new 6/4 -> Q=1, R=2.
REQ-034 Exhaustive sweep of all 256 A/B pairs -> REQ-022 holds for B!=0, REQ-021 holds for B=0, and every case has latency 5 edges.
